min_select: RTL

MIN_SELECT -- requirements
Module: min_select

---
 rtl/min_select.sv | 139 +++++++++++++
 1 files changed

// File: rtl/min_select.sv
// Streaming minimum selector with Avalon-MM control; tracks the smallest distance sample and its index.
// Zero-latency combinational reads, one-cycle writes; in_ready is withheld in any cycle carrying a slave write.
module min_select #(
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] slave_address,
  input  logic                     slave_read,
  output logic [31:0]              slave_readdata,
  input  logic                     slave_write,
  input  logic [31:0]              slave_writedata,
  output logic                     slave_waitrequest,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  output logic                     done_irq
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DONE   = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_CTRL     = ADDRESS_WIDTH'(0);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LEN      = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MIN_DIST = ADDRESS_WIDTH'(2);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MIN_IDX  = ADDRESS_WIDTH'(3);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_COUNT    = ADDRESS_WIDTH'(4);

  localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

  state_t      state;
  state_t      state_next;
  logic [31:0] len;
  logic [31:0] count;
  logic [31:0] min_dist;
  logic [31:0] min_idx;
  logic        empty;

  logic        ctrl_wr;
  logic        len_wr;
  logic        abort_req;
  logic        start_req;
  logic        xfer;
  logic        last_xfer;
  logic        take;
  logic [31:0] count_next;

  assign ctrl_wr   = slave_write && (slave_address == ADDR_CTRL);
  assign len_wr    = slave_write && (slave_address == ADDR_LEN) && (state != ST_ACTIVE);
  assign abort_req = ctrl_wr && slave_writedata[4];
  // ABORT takes priority, and a restart is only honoured outside ACTIVE.
  assign start_req = ctrl_wr && slave_writedata[2] && !slave_writedata[4] &&
                     ((state == ST_IDLE) || (state == ST_DONE));

  assign in_ready   = (state == ST_ACTIVE) && !slave_write;
  assign xfer       = in_valid && in_ready;
  assign count_next = count + 32'd1;
  assign last_xfer  = xfer && (count_next == len);
  // Strict compare keeps the earliest index on ties; the sentinel never wins.
  assign take       = xfer && (in_data != SENTINEL) && (in_data < min_dist);

  assign done_irq          = (state == ST_DONE);
  assign slave_waitrequest = 1'b0;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else if (start_req) begin
          state_next = (len == 32'd0) ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else if (last_xfer) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len      <= 32'd0;
      count    <= 32'd0;
      min_dist <= SENTINEL;
      min_idx  <= 32'd0;
      empty    <= 1'b1;
    end else begin
      if (len_wr) begin
        len <= slave_writedata;
      end
      if (start_req) begin
        count    <= 32'd0;
        min_dist <= SENTINEL;
        min_idx  <= 32'd0;
        empty    <= 1'b1;
      end else if (xfer) begin
        count <= count_next;
        if (take) begin
          min_dist <= in_data;
          min_idx  <= count;
          empty    <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    slave_readdata = SENTINEL;
    if (slave_read) begin
      case (slave_address)
        ADDR_CTRL:     slave_readdata = {27'd0, 1'b0, empty, 1'b0, state};
        ADDR_LEN:      slave_readdata = len;
        ADDR_MIN_DIST: slave_readdata = min_dist;
        ADDR_MIN_IDX:  slave_readdata = min_idx;
        ADDR_COUNT:    slave_readdata = count;
        default:       slave_readdata = 32'd0;
      endcase
    end
  end

endmodule
